ec_fp_mod_add_stream: RTL and testbench
=======================================

EC_FP_MOD_ADD_STREAM -- requirements
Module: ec_fp_mod_add_stream

Interface
REQ-001 SHALL have parameter ARITH_BITS, default 64, word width of the arithmetic stream (power of 2).
REQ-002 SHALL have parameter DIV, default 6, words per field element (DIV*ARITH_BITS = element width).
REQ-003 SHALL have parameter P, default BLS12-381 base modulus (from package), modulus; a, b < P assumed by caller.
REQ-004 SHALL have parameter CTL_BITS, default 8, sideband tag width.
REQ-005 SHALL have one clock; reset is asynchronous and active-low; ports: i_clk  in  1  clock; i_rst_n  in  1  async active-low reset.
REQ-006 SHALL have i_add_if (if_axi_stream sink): dat in 2*ARITH_BITS, [ARITH_BITS-1:0]=a word, [2*ARITH_BITS-1:ARITH_BITS]=b word; val in 1; rdy out 1; sop in 1; eop in 1; ctl in CTL_BITS.
REQ-007 SHALL have o_add_if (if_axi_stream source): dat out ARITH_BITS, result word; val out 1; rdy in 1; sop out 1; eop out 1; ctl out CTL_BITS; err out 1.

Function
REQ-008 SHALL compute (a+b) mod P per element, words little-endian (word 0 = LS), first word flagged sop, last eop.
REQ-009 SHALL have states ACCUM and OUTPUT; ACCUM asserts i_add_if.rdy, OUTPUT deasserts it.
REQ-010 In ACCUM, per accepted word k, SHALL form s_k = a_k+b_k+carry and d_k = s_k-P_k-borrow, storing both words; carry/borrow cleared on sop.
REQ-011 SHALL latch i_add_if.ctl on the sop word and echo it on every output word.
REQ-012 On accepting eop, SHALL select d if (final carry=1 or final borrow=0), else s, and move to OUTPUT.
REQ-013 SHALL present output word 0 with val=1 on the cycle after eop is accepted (latency 1 cycle from eop).
REQ-014 In OUTPUT, SHALL advance one word per cycle when val&rdy; hold dat/sop/eop/ctl stable while val&~rdy.
REQ-015 After eop word transfers, SHALL return to ACCUM with rdy=1 on the next cycle; min element period DIV+1 (accept) + DIV (drain) cycles.
REQ-016 Input word counter SHALL wrap to 0 on eop; sop arriving mid-element SHALL restart counter and discard partial data.
REQ-017 eop at counter != DIV-1 SHALL still produce DIV output words with err=1 on the output eop word; err=0 otherwise.
REQ-018 DIV=1 SHALL work: single word carries sop=eop=1 on input and output.
REQ-019 val on o_add_if SHALL never deassert before rdy while a word is pending.

Reset
REQ-020 While i_rst_n=0: state=ACCUM, i_add_if.rdy=0, o_add_if.val/sop/eop/err=0, dat=0, ctl=0, counters, carry, borrow, buffers=0.
REQ-021 i_add_if.rdy SHALL rise on the first clock edge after reset release.
REQ-022 Reset mid-element or mid-drain SHALL abandon the element; no partial output after release.

Structure
REQ-023 Modulus constants and FE/arith word typedefs SHALL live in the shared EC package; no local copies.
REQ-024 One sub-module is natural: fp_word_addsub (combinational word add with carry and subtract-P-word with borrow), instanced once.
REQ-025 Block SHALL drop in as the adder serving o_add_if/i_add_if of the Jacobian doubling engine; a sub variant is out of scope.

Verification (ARITH_BITS=8, DIV=2, P=0xFFF1)
REQ-026 a=0x0001, b=0x0002, ctl=0x08 -> out words 0x03,0x00, sop/eop correct, ctl=0x08, err=0.
REQ-027 a=0xFFF0, b=0x0001 (sum = P) -> out 0x00,0x00; a=0x8000, b=0x8000 (carry out) -> out 0x0F,0x00.
REQ-028 a=0xFFF0, b=0x0000 -> out 0xF0,0xFF (no reduction); back-to-back 100 random pairs vs model -> all match.
REQ-029 o_add_if.rdy toggled randomly 50% during OUTPUT -> words stable while stalled, order/values unchanged, i_add_if.rdy=0 throughout drain.
REQ-030 eop on word 0 (short element) -> two output words, err=1 on eop word only; next good element err=0.
REQ-031 i_rst_n pulsed low after first input word -> all outputs 0, rdy=1 one edge after release, next element correct.

Source files
------------

// File: rtl/ec_fp_mod_add_stream_pkg.sv
// Shared EC field-arithmetic package: modulus constants, element/word types
// and the state encoding of the streaming modular adder.
package ec_fp_mod_add_stream_pkg;

  localparam int FE_BITS    = 384;
  localparam int WORD_BITS  = 64;
  localparam int FE_WORDS   = FE_BITS / WORD_BITS;

  typedef logic [FE_BITS-1:0]   fe_t;
  typedef logic [WORD_BITS-1:0] arith_word_t;

  // BLS12-381 base field modulus, zero-extended to the 384-bit element width.
  localparam fe_t BLS12_381_P = fe_t'(381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } add_state_e;

endpackage

// File: rtl/ec_fp_mod_add_stream_fp_word_addsub.sv
// One word of a multi-word add (a+b+carry) and of the trial subtraction of
// the modulus word from that sum (s-p-borrow). Purely combinational.
module fp_word_addsub
  import ec_fp_mod_add_stream_pkg::*;
#(
  parameter int ARITH_BITS = 64
) (
  input  logic [ARITH_BITS-1:0] a_i,
  input  logic [ARITH_BITS-1:0] b_i,
  input  logic [ARITH_BITS-1:0] p_i,
  input  logic                  carry_i,
  input  logic                  borrow_i,
  output logic [ARITH_BITS-1:0] s_o,
  output logic                  carry_o,
  output logic [ARITH_BITS-1:0] d_o,
  output logic                  borrow_o
);

  logic [ARITH_BITS:0] sum_full;
  logic [ARITH_BITS:0] diff_full;

  // Sum word with carry-out, then subtract the modulus word; the top bit of
  // the difference wraps to 1 exactly when a borrow is needed.
  always_comb begin
    sum_full  = {1'b0, a_i} + {1'b0, b_i} + {{ARITH_BITS{1'b0}}, carry_i};
    diff_full = {1'b0, sum_full[ARITH_BITS-1:0]} - {1'b0, p_i}
                - {{ARITH_BITS{1'b0}}, borrow_i};
    s_o       = sum_full[ARITH_BITS-1:0];
    carry_o   = sum_full[ARITH_BITS];
    d_o       = diff_full[ARITH_BITS-1:0];
    borrow_o  = diff_full[ARITH_BITS];
  end

endmodule

// File: rtl/ec_fp_mod_add_stream.sv
// Streaming modular adder: accepts (a,b) word pairs LS-word first, keeps both
// a+b and a+b-P, picks the reduced one at eop and streams it back out.
module ec_fp_mod_add_stream
  import ec_fp_mod_add_stream_pkg::*;
#(
  parameter int                          ARITH_BITS = 64,
  parameter int                          DIV        = 6,
  parameter logic [DIV*ARITH_BITS-1:0]   P          = BLS12_381_P,
  parameter int                          CTL_BITS   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  // i_add_if sink: dat = {b word, a word}
  input  logic [2*ARITH_BITS-1:0] add_dat_i,
  input  logic                    add_val_i,
  output logic                    add_rdy_o,
  input  logic                    add_sop_i,
  input  logic                    add_eop_i,
  input  logic [CTL_BITS-1:0]     add_ctl_i,
  // o_add_if source
  output logic [ARITH_BITS-1:0]   res_dat_o,
  output logic                    res_val_o,
  input  logic                    res_rdy_i,
  output logic                    res_sop_o,
  output logic                    res_eop_o,
  output logic [CTL_BITS-1:0]     res_ctl_o,
  output logic                    res_err_o
);

  localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  add_state_e                state_q, state_d;
  logic                      rdy_q, rdy_d;
  logic [CNT_W-1:0]          in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;
  logic                      carry_q, carry_d;
  logic                      borrow_q, borrow_d;
  logic                      sel_q, sel_d;
  logic                      err_q, err_d;
  logic                      val_q, val_d;
  logic [CTL_BITS-1:0]       ctl_q, ctl_d;
  logic [ARITH_BITS-1:0]     s_buf_q [DIV];
  logic [ARITH_BITS-1:0]     s_buf_d [DIV];
  logic [ARITH_BITS-1:0]     d_buf_q [DIV];
  logic [ARITH_BITS-1:0]     d_buf_d [DIV];

  logic [CNT_W-1:0]          word_idx;
  logic                      carry_in, borrow_in;
  logic [ARITH_BITS-1:0]     p_word;
  logic [ARITH_BITS-1:0]     s_word, d_word;
  logic                      carry_out, borrow_out;
  logic                      accept;

  // A sop word always restarts the element: index 0 and fresh carry/borrow.
  always_comb begin
    word_idx  = add_sop_i ? '0   : in_cnt_q;
    carry_in  = add_sop_i ? 1'b0 : carry_q;
    borrow_in = add_sop_i ? 1'b0 : borrow_q;
    p_word    = P[word_idx*ARITH_BITS +: ARITH_BITS];
    accept    = add_val_i & rdy_q;
  end

  fp_word_addsub #(
    .ARITH_BITS(ARITH_BITS)
  ) u_addsub (
    .a_i      (add_dat_i[ARITH_BITS-1:0]),
    .b_i      (add_dat_i[2*ARITH_BITS-1:ARITH_BITS]),
    .p_i      (p_word),
    .carry_i  (carry_in),
    .borrow_i (borrow_in),
    .s_o      (s_word),
    .carry_o  (carry_out),
    .d_o      (d_word),
    .borrow_o (borrow_out)
  );

  // Next-state logic for accumulation, reduction select and drain.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    carry_d   = carry_q;
    borrow_d  = borrow_q;
    sel_d     = sel_q;
    err_d     = err_q;
    val_d     = val_q;
    ctl_d     = ctl_q;
    s_buf_d   = s_buf_q;
    d_buf_d   = d_buf_q;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          s_buf_d[word_idx] = s_word;
          d_buf_d[word_idx] = d_word;
          carry_d           = carry_out;
          borrow_d          = borrow_out;
          if (add_sop_i) begin
            ctl_d = add_ctl_i;
          end
          if (add_eop_i) begin
            // a+b < 2P, so a+b >= P exactly when the sum overflowed the
            // element width or the trial subtraction did not borrow.
            sel_d     = carry_out | ~borrow_out;
            err_d     = (word_idx != LAST);
            in_cnt_d  = '0;
            out_cnt_d = '0;
            val_d     = 1'b1;
            state_d   = ST_OUTPUT;
          end else begin
            in_cnt_d  = (word_idx == LAST) ? word_idx : CNT_W'(word_idx + 1'b1);
          end
        end
      end
      ST_OUTPUT: begin
        if (val_q && res_rdy_i) begin
          if (out_cnt_q == LAST) begin
            val_d   = 1'b0;
            state_d = ST_ACCUM;
          end else begin
            out_cnt_d = CNT_W'(out_cnt_q + 1'b1);
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    rdy_d = (state_d == ST_ACCUM);
  end

  // State, control and buffer registers; everything clears on reset so an
  // interrupted element leaves no trace.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_ACCUM;
      rdy_q     <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
      sel_q     <= 1'b0;
      err_q     <= 1'b0;
      val_q     <= 1'b0;
      ctl_q     <= '0;
      for (int i = 0; i < DIV; i++) begin
        s_buf_q[i] <= '0;
        d_buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      carry_q   <= carry_d;
      borrow_q  <= borrow_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      val_q     <= val_d;
      ctl_q     <= ctl_d;
      s_buf_q   <= s_buf_d;
      d_buf_q   <= d_buf_d;
    end
  end

  assign add_rdy_o = rdy_q;
  assign res_val_o = val_q;
  assign res_dat_o = sel_q ? d_buf_q[out_cnt_q] : s_buf_q[out_cnt_q];
  assign res_sop_o = val_q & (out_cnt_q == '0);
  assign res_eop_o = val_q & (out_cnt_q == LAST);
  assign res_err_o = val_q & (out_cnt_q == LAST) & err_q;
  assign res_ctl_o = ctl_q;

endmodule

// File: tb/tb_ec_fp_mod_add_stream.sv
// Directed bench for ec_fp_mod_add_stream at ARITH_BITS=8, DIV=2, P=0xFFF1.
module tb_ec_fp_mod_add_stream;

  localparam int AB = 8;
  localparam int DV = 2;
  localparam int CB = 8;
  localparam int PM = 32'hFFF1;

  logic          clk;
  logic          rst_n;
  logic [2*AB-1:0] add_dat_i;
  logic          add_val_i;
  logic          add_rdy_o;
  logic          add_sop_i;
  logic          add_eop_i;
  logic [CB-1:0] add_ctl_i;
  logic [AB-1:0] res_dat_o;
  logic          res_val_o;
  logic          res_rdy_i;
  logic          res_sop_o;
  logic          res_eop_o;
  logic [CB-1:0] res_ctl_o;
  logic          res_err_o;

  int checks = 0;
  int errors = 0;

  logic [AB-1:0] got_dat [DV];
  logic          got_sop [DV];
  logic          got_eop [DV];
  logic          got_err [DV];
  logic [CB-1:0] got_ctl [DV];

  ec_fp_mod_add_stream #(
    .ARITH_BITS(AB),
    .DIV(DV),
    .P(16'hFFF1),
    .CTL_BITS(CB)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .add_dat_i (add_dat_i),
    .add_val_i (add_val_i),
    .add_rdy_o (add_rdy_o),
    .add_sop_i (add_sop_i),
    .add_eop_i (add_eop_i),
    .add_ctl_i (add_ctl_i),
    .res_dat_o (res_dat_o),
    .res_val_o (res_val_o),
    .res_rdy_i (res_rdy_i),
    .res_sop_o (res_sop_o),
    .res_eop_o (res_eop_o),
    .res_ctl_o (res_ctl_o),
    .res_err_o (res_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input word starting at a negedge; returns at the next negedge.
  task automatic drive_word(input logic [15:0] d, input logic s, input logic e,
                            input logic [7:0] c);
    int n = 0;
    while (!add_rdy_o && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (!add_rdy_o) begin
      checks++; errors++;
      $display("FAIL drive_rdy_timeout: rdy=%0b after %0d cycles, required 1", add_rdy_o, n);
    end
    add_dat_i = d; add_sop_i = s; add_eop_i = e; add_ctl_i = c; add_val_i = 1'b1;
    @(posedge clk); @(negedge clk);
    add_val_i = 1'b0; add_sop_i = 1'b0; add_eop_i = 1'b0;
  endtask

  task automatic send_elem(input logic [15:0] a, input logic [15:0] b, input logic [7:0] c);
    drive_word({b[7:0], a[7:0]}, 1'b1, 1'b0, c);
    drive_word({b[15:8], a[15:8]}, 1'b0, 1'b1, ~c);
  endtask

  // Capture DV output words with res_rdy_i held high.
  task automatic collect();
    int g = 0;
    int n = 0;
    while (g < DV && n < 40) begin
      if (res_val_o && res_rdy_i) begin
        got_dat[g] = res_dat_o; got_sop[g] = res_sop_o; got_eop[g] = res_eop_o;
        got_err[g] = res_err_o; got_ctl[g] = res_ctl_o;
        g++;
      end
      @(posedge clk); @(negedge clk); n++;
    end
    if (g < DV) begin
      checks++; errors++;
      $display("FAIL collect_timeout: got %0d words, required %0d", g, DV);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (add_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %0b want 0", add_rdy_o); end
    checks++; if (res_val_o !== 1'b0) begin errors++; $display("FAIL reset_val: got %0b want 0", res_val_o); end
    checks++; if ({res_sop_o, res_eop_o, res_err_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {res_sop_o, res_eop_o, res_err_o}); end
    checks++; if (res_dat_o !== 8'h00 || res_ctl_o !== 8'h00) begin errors++; $display("FAIL reset_dat_ctl: got %h/%h want 00/00", res_dat_o, res_ctl_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (add_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy_before_edge: got %0b want 0", add_rdy_o); end
    @(posedge clk); @(negedge clk);
    checks++; if (add_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy_after_edge: got %0b want 1", add_rdy_o); end
  endtask

  task automatic test_basic();
    send_elem(16'h0001, 16'h0002, 8'h08);
    checks++; if (res_val_o !== 1'b1) begin errors++; $display("FAIL basic_latency: val=%0b want 1 one cycle after eop", res_val_o); end
    checks++; if (add_rdy_o !== 1'b0) begin errors++; $display("FAIL basic_rdy_drain: got %0b want 0", add_rdy_o); end
    collect();
    checks++; if (got_dat[0] !== 8'h03 || got_dat[1] !== 8'h00) begin errors++; $display("FAIL basic_dat: got %h,%h want 03,00", got_dat[0], got_dat[1]); end
    checks++; if ({got_sop[0], got_eop[0], got_sop[1], got_eop[1]} !== 4'b1001) begin errors++; $display("FAIL basic_sop_eop: got %b want 1001", {got_sop[0], got_eop[0], got_sop[1], got_eop[1]}); end
    checks++; if (got_ctl[0] !== 8'h08 || got_ctl[1] !== 8'h08) begin errors++; $display("FAIL basic_ctl: got %h,%h want 08,08", got_ctl[0], got_ctl[1]); end
    checks++; if (got_err[0] !== 1'b0 || got_err[1] !== 1'b0) begin errors++; $display("FAIL basic_err: got %0b,%0b want 0,0", got_err[0], got_err[1]); end
    checks++; if (add_rdy_o !== 1'b1) begin errors++; $display("FAIL basic_rdy_return: got %0b want 1", add_rdy_o); end
  endtask

  task automatic test_reduce();
    send_elem(16'hFFF0, 16'h0001, 8'h11);
    collect();
    checks++; if (got_dat[0] !== 8'h00 || got_dat[1] !== 8'h00) begin errors++; $display("FAIL reduce_eq_p: got %h,%h want 00,00", got_dat[0], got_dat[1]); end
    send_elem(16'h8000, 16'h8000, 8'h22);
    collect();
    checks++; if (got_dat[0] !== 8'h0F || got_dat[1] !== 8'h00) begin errors++; $display("FAIL reduce_carry: got %h,%h want 0F,00", got_dat[0], got_dat[1]); end
    send_elem(16'hFFF0, 16'h0000, 8'h33);
    collect();
    checks++; if (got_dat[0] !== 8'hF0 || got_dat[1] !== 8'hFF) begin errors++; $display("FAIL reduce_none: got %h,%h want F0,FF", got_dat[0], got_dat[1]); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      logic [15:0] a, b, e;
      int sum;
      a = 16'($urandom_range(0, PM - 1));
      b = 16'($urandom_range(0, PM - 1));
      sum = (int'(a) + int'(b)) % PM;
      e = 16'(sum);
      send_elem(a, b, 8'(i));
      collect();
      checks++;
      if ({got_dat[1], got_dat[0]} !== e || got_ctl[1] !== 8'(i)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL b2b_%0d: a=%h b=%h got %h ctl %h want %h ctl %h", i, a, b, {got_dat[1], got_dat[0]}, got_ctl[1], e, 8'(i));
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 5; k++) begin
      logic [15:0] a, b, e;
      logic [AB-1:0] got [DV];
      logic [AB-1:0] h_dat;
      logic [CB-1:0] h_ctl;
      logic h_sop, h_eop, held;
      int g, n;
      a = 16'h1234 + 16'(k * 16'h3111);
      b = 16'hF000 - 16'(k * 16'h0101);
      e = 16'((int'(a) + int'(b)) % PM);
      res_rdy_i = 1'b0;
      send_elem(a, b, 8'hA0 + 8'(k));
      g = 0; n = 0; held = 1'b0;
      h_dat = '0; h_ctl = '0; h_sop = 1'b0; h_eop = 1'b0;
      while (g < DV && n < 200) begin
        if (held) begin
          checks++;
          if (res_val_o !== 1'b1 || res_dat_o !== h_dat || res_ctl_o !== h_ctl ||
              res_sop_o !== h_sop || res_eop_o !== h_eop) begin
            errors++; $display("FAIL stall_hold_%0d: val=%0b dat=%h ctl=%h sop=%0b eop=%0b want 1 %h %h %0b %0b", k, res_val_o, res_dat_o, res_ctl_o, res_sop_o, res_eop_o, h_dat, h_ctl, h_sop, h_eop);
          end
        end
        if (res_val_o && add_rdy_o !== 1'b0) begin
          checks++; errors++; $display("FAIL stall_in_rdy_%0d: got %0b want 0", k, add_rdy_o);
        end
        res_rdy_i = 1'($urandom_range(0, 1));
        held = 1'b0;
        if (res_val_o) begin
          if (res_rdy_i) begin
            got[g] = res_dat_o; g++;
          end else begin
            held = 1'b1; h_dat = res_dat_o; h_ctl = res_ctl_o; h_sop = res_sop_o; h_eop = res_eop_o;
          end
        end
        @(posedge clk); @(negedge clk); n++;
      end
      res_rdy_i = 1'b1;
      checks++;
      if (g < DV || {got[1], got[0]} !== e) begin
        errors++; $display("FAIL stall_data_%0d: got %h (%0d words) want %h", k, {got[1], got[0]}, g, e);
      end
    end
  endtask

  task automatic test_short();
    drive_word({8'h03, 8'h05}, 1'b1, 1'b1, 8'h5A);
    collect();
    checks++; if (got_dat[0] !== 8'h08) begin errors++; $display("FAIL short_word0: got %h want 08", got_dat[0]); end
    checks++; if (got_err[0] !== 1'b0 || got_err[1] !== 1'b1) begin errors++; $display("FAIL short_err: got %0b,%0b want 0,1", got_err[0], got_err[1]); end
    checks++; if ({got_sop[0], got_eop[1], got_ctl[1]} !== {1'b1, 1'b1, 8'h5A}) begin errors++; $display("FAIL short_flags: got %b want 1101011010", {got_sop[0], got_eop[1], got_ctl[1]}); end
    send_elem(16'h0102, 16'h0203, 8'h66);
    collect();
    checks++; if (got_err[1] !== 1'b0 || {got_dat[1], got_dat[0]} !== 16'h0305) begin errors++; $display("FAIL short_recover: err=%0b dat=%h want 0 0305", got_err[1], {got_dat[1], got_dat[0]}); end
  endtask

  task automatic test_restart();
    drive_word({8'h11, 8'h22}, 1'b1, 1'b0, 8'h77);
    send_elem(16'h00FF, 16'h0001, 8'h78);
    collect();
    checks++; if ({got_dat[1], got_dat[0]} !== 16'h0100 || got_ctl[0] !== 8'h78) begin errors++; $display("FAIL restart: got %h ctl %h want 0100 ctl 78", {got_dat[1], got_dat[0]}, got_ctl[0]); end
  endtask

  task automatic test_reset_mid();
    drive_word({8'h44, 8'h33}, 1'b1, 1'b0, 8'h99);
    rst_n = 1'b0;
    #1;
    checks++; if ({add_rdy_o, res_val_o, res_sop_o, res_eop_o, res_err_o} !== 5'b0 || res_dat_o !== 8'h00 || res_ctl_o !== 8'h00) begin errors++; $display("FAIL midrst_outputs: rdy=%0b val=%0b dat=%h ctl=%h want all 0", add_rdy_o, res_val_o, res_dat_o, res_ctl_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (add_rdy_o !== 1'b0) begin errors++; $display("FAIL midrst_rdy_before: got %0b want 0", add_rdy_o); end
    @(posedge clk); @(negedge clk);
    checks++; if (add_rdy_o !== 1'b1 || res_val_o !== 1'b0) begin errors++; $display("FAIL midrst_release: rdy=%0b val=%0b want 1 0", add_rdy_o, res_val_o); end
    send_elem(16'h0010, 16'h0020, 8'h42);
    collect();
    checks++; if ({got_dat[1], got_dat[0]} !== 16'h0030 || got_ctl[1] !== 8'h42 || got_err[1] !== 1'b0) begin errors++; $display("FAIL midrst_next: got %h ctl %h err %0b want 0030 ctl 42 err 0", {got_dat[1], got_dat[0]}, got_ctl[1], got_err[1]); end
  endtask

  initial begin
    rst_n = 1'b0; add_dat_i = '0; add_val_i = 1'b0; add_sop_i = 1'b0;
    add_eop_i = 1'b0; add_ctl_i = '0; res_rdy_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_reduce();
    test_back_to_back();
    test_stall();
    test_short();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
